board_scan_controller: RTL and testbench
========================================

// Module: board_scan_controller
// PURPOSE
//  Sequences end-of-move win/draw detection for the Connect Four board.
//  Arbitrates the single board read port (row_read/col_read -> data_out) between the VGA renderer and the scanner.
//  The board is copied into a shadow during vertical blanking, then checked for four-in-a-row off the port.
//  Sits between connect_four and the top-level renderer; drives the game_over/winner status.
// PARAMETERS
//  ROWS      8    board rows; row 0 = bottom
//  COLS      8    board columns
//  V_ACTIVE  480  first blanking line (v_count value)
//  V_TOTAL   525  lines per frame
// PORTS
//  clk_25MHz      in   1   pixel clock; sole clock
//  rst_n          in   1   synchronous active-low reset
//  scan_req       in   1   one-cycle pulse from game logic after a piece lands
//  v_count        in   10  current VGA line
//  vga_row_read   in   3   renderer row address
//  vga_col_read   in   3   renderer column address
//  board_data     in   2   board cell value (combinational read of the addressed cell)
//  board_row_read out  3   muxed row address to board
//  board_col_read out  3   muxed column address to board
//  vga_data       out  2   board_data forwarded to renderer
//  scan_busy      out  1   high in every state except IDLE
//  scan_done      out  1   one-cycle pulse on DONE
//  win            out  1   sticky: four in a row found
//  winner         out  2   player code of the winning line; valid while win=1
//  draw           out  1   sticky: board full, no win
// BEHAVIOUR
//  Reset: state=IDLE, idx=0, pending=0, shadow=0.
//   All outputs 0, except board_*_read and vga_data, which are the renderer pass-through.
//  FSM: IDLE -> WAIT_BLANK -> COPY -> CHECK -> DONE -> IDLE | WAIT_BLANK.
//  IDLE: scan_req & ~win & ~draw -> WAIT_BLANK next cycle; otherwise scan_req is ignored.
//  WAIT_BLANK: enter COPY only when V_ACTIVE <= v_count <= V_TOTAL-2.
//   Starting on the last line is forbidden; this guarantees COPY ends inside blanking.
//  COPY: 64 cycles, idx 0..63. board_row_read=idx[5:3], board_col_read=idx[2:0].
//   shadow[idx] <= board_data in the same cycle.
//   Renderer addresses are ignored only in this state; vga_data is don't-care (blanking).
//   After idx=63: idx<=0 -> CHECK.
//  CHECK: one anchor cell per cycle, idx 0..63 (r=idx[5:3], c=idx[2:0]).
//   Four directions are evaluated in parallel:
//     H  (r,c..c+3),         c<=COLS-4
//     V  (r..r+3,c),         r<=ROWS-4
//     D+ (r+k,c+k),          r,c<=4
//     D- (r+k,c-k),          r<=4, c>=3
//   Out-of-range windows never match.
//   A window matches if its 4 cells are equal and nonzero.
//   First match: win<=1, winner<=anchor cell -> DONE. Remaining anchors are skipped.
//   idx=63 without a match: draw<=(no zero cell in shadow) -> DONE.
//  DONE: scan_done=1 for exactly one cycle.
//   If pending & ~win & ~draw -> WAIT_BLANK; otherwise -> IDLE. pending is cleared on leaving DONE.
//  scan_req while busy sets pending; multiple requests collapse into one rescan.
//  win, winner and draw hold until reset. They are mutually exclusive.
//  Worst-case latency from DONE/IDLE to the result: WAIT_BLANK (<=1 frame) + 64 + 64 + 1 cycles.
//  Reset asserted mid-COPY/CHECK: aborts in the next cycle to reset values; a partial shadow is discarded.
//  idx is 6 bits; the row/column windows are computed with 4-bit sums so c+3 cannot wrap.
// STRUCTURE
//  Package connect_four_pkg: ROWS, COLS, EMPTY=2'b00, PLAYER1=2'b01, PLAYER2=2'b10,
//   typedef cell_t [1:0], scan state enum.
//  Sub-module c4_line_match: combinational, 4 x cell_t in -> match, player out.
//   Instantiated 4x, one per direction.
//  The shadow is a 64 x 2-bit flat register.
// TESTING
//  1 Bottom row P1 at cols 2..5, scan_req at v_count=100
//    -> COPY starts at v_count=480; win=1, winner=01 within 130 cycles of COPY start; scan_done pulses once.
//  2 P2 vertical at col 7, rows 0..3 -> win=1, winner=10. P2 D- diagonal (0,6)(1,5)(2,4)(3,3) -> same result.
//  3 Three P1 at cols 5..7 in row 0 plus P1 at (1,0), i.e. no wrap
//    -> scan_done pulses, win=0, draw=0.
//  4 Full board with alternating pattern, no four in a row -> draw=1, win=0.
//  5 scan_req twice during CHECK
//    -> exactly one extra scan, waiting for the next blanking; a single further scan_done.
//    scan_req when v_count=524 -> COPY waits for line 480 of the next frame.
//  6 rst_n=0 at COPY idx=30
//    -> next cycle state=IDLE and all outputs at reset values.
//    During COPY the board address equals idx, not the vga_* inputs; outside COPY it equals the vga_* inputs.

Source files
------------

// File: rtl/connect_four_pkg.sv
// Shared definitions for the Connect Four board logic.
//  - Board geometry (ROWS x COLS, row 0 = bottom)
//  - Cell encoding (EMPTY / PLAYER1 / PLAYER2)
//  - Scan controller state encoding
package connect_four_pkg;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    typedef logic [1:0] cell_t;

    localparam cell_t EMPTY   = 2'b00;
    localparam cell_t PLAYER1 = 2'b01;
    localparam cell_t PLAYER2 = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_BLANK,
        S_COPY,
        S_CHECK,
        S_DONE
    } scan_state_t;

endpackage

// File: rtl/c4_line_match.sv
// Combinational four-in-a-row detector for one window of four cells.
// Ports:
//  cell0..cell3  in   cell_t  the four cells of the window, anchor first
//  match         out  1       all four cells equal and not EMPTY
//  player        out  cell_t  owner of the line when match=1, EMPTY otherwise
module c4_line_match
    import connect_four_pkg::*;
(
    input  cell_t cell0,
    input  cell_t cell1,
    input  cell_t cell2,
    input  cell_t cell3,
    output logic  match,
    output cell_t player
);

    always_comb begin
        match  = (cell0 != EMPTY) && (cell0 == cell1) && (cell1 == cell2) && (cell2 == cell3);
        player = match ? cell0 : EMPTY;
    end

endmodule

// File: rtl/board_scan_controller.sv
// End-of-move win/draw scanner for the Connect Four board.
// Shares the single board read port with the VGA renderer: during vertical
// blanking the board is copied into a shadow register, then every anchor
// cell of the shadow is tested for four-in-a-row in four directions.
// Ports:
//  clk_25MHz       in   1   pixel clock
//  rst_n           in   1   synchronous active-low reset
//  scan_req        in   1   pulse after a piece lands
//  v_count         in   10  current VGA line
//  vga_row_read    in   3   renderer row address
//  vga_col_read    in   3   renderer column address
//  board_data      in   2   combinational read of the addressed cell
//  board_row_read  out  3   muxed row address to the board
//  board_col_read  out  3   muxed column address to the board
//  vga_data        out  2   board_data forwarded to the renderer
//  scan_busy       out  1   controller not idle
//  scan_done       out  1   one-cycle pulse when a scan finishes
//  win             out  1   sticky: four in a row found
//  winner          out  2   player owning the winning line
//  draw            out  1   sticky: board full without a win
module board_scan_controller
    import connect_four_pkg::*;
#(
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic       clk_25MHz,
    input  logic       rst_n,
    input  logic       scan_req,
    input  logic [9:0] v_count,
    input  logic [2:0] vga_row_read,
    input  logic [2:0] vga_col_read,
    input  logic [1:0] board_data,
    output logic [2:0] board_row_read,
    output logic [2:0] board_col_read,
    output logic [1:0] vga_data,
    output logic       scan_busy,
    output logic       scan_done,
    output logic       win,
    output logic [1:0] winner,
    output logic       draw
);

    localparam logic [3:0] ROW_ANCHOR_MAX = 4'(ROWS - 4);
    localparam logic [3:0] COL_ANCHOR_MAX = 4'(COLS - 4);

    scan_state_t  state;
    logic [5:0]   idx;
    logic         pending;
    logic [127:0] shadow;

    // Out-of-range coordinates read as EMPTY so a window spilling off the
    // board can never match, even if the range gate were missing.
    function automatic cell_t cell_at(input logic [127:0] sh,
                                      input logic [3:0]   r,
                                      input logic [3:0]   c);
        if (r < 4'(ROWS) && c < 4'(COLS))
            cell_at = sh[{r[2:0], c[2:0], 1'b0} +: 2];
        else
            cell_at = EMPTY;
    endfunction

    function automatic logic board_full(input logic [127:0] sh);
        board_full = 1'b1;
        for (int i = 0; i < ROWS * COLS; i++)
            if (sh[2*i +: 2] == EMPTY)
                board_full = 1'b0;
    endfunction

    // Copy may only start on a line that still leaves 64 cycles of blanking.
    logic vblank_ok;
    assign vblank_ok = (v_count >= 10'(V_ACTIVE)) && (v_count <= 10'(V_TOTAL - 2));

    // Board port arbitration: the scanner owns the address only while copying.
    always_comb begin
        if (state == S_COPY) begin
            board_row_read = idx[5:3];
            board_col_read = idx[2:0];
        end else begin
            board_row_read = vga_row_read;
            board_col_read = vga_col_read;
        end
    end

    assign vga_data  = board_data;
    assign scan_busy = (state != S_IDLE);
    assign scan_done = (state == S_DONE);

    // Anchor coordinates widened to 4 bits so c+3 / r+3 do not wrap.
    logic [3:0] anchor_r, anchor_c;
    assign anchor_r = {1'b0, idx[5:3]};
    assign anchor_c = {1'b0, idx[2:0]};

    cell_t h_cells  [4];
    cell_t v_cells  [4];
    cell_t dp_cells [4];
    cell_t dm_cells [4];

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            h_cells[k]  = cell_at(shadow, anchor_r,          anchor_c + 4'(k));
            v_cells[k]  = cell_at(shadow, anchor_r + 4'(k),  anchor_c);
            dp_cells[k] = cell_at(shadow, anchor_r + 4'(k),  anchor_c + 4'(k));
            dm_cells[k] = cell_at(shadow, anchor_r + 4'(k),  anchor_c - 4'(k));
        end
    end

    logic  h_match, v_match, dp_match, dm_match;
    cell_t h_player, v_player, dp_player, dm_player;

    c4_line_match u_match_h (
        .cell0 (h_cells[0]), .cell1 (h_cells[1]), .cell2 (h_cells[2]), .cell3 (h_cells[3]),
        .match (h_match),    .player(h_player)
    );
    c4_line_match u_match_v (
        .cell0 (v_cells[0]), .cell1 (v_cells[1]), .cell2 (v_cells[2]), .cell3 (v_cells[3]),
        .match (v_match),    .player(v_player)
    );
    c4_line_match u_match_dp (
        .cell0 (dp_cells[0]), .cell1 (dp_cells[1]), .cell2 (dp_cells[2]), .cell3 (dp_cells[3]),
        .match (dp_match),    .player(dp_player)
    );
    c4_line_match u_match_dm (
        .cell0 (dm_cells[0]), .cell1 (dm_cells[1]), .cell2 (dm_cells[2]), .cell3 (dm_cells[3]),
        .match (dm_match),    .player(dm_player)
    );

    logic h_hit, v_hit, dp_hit, dm_hit, any_hit;
    cell_t hit_player;

    always_comb begin
        h_hit   = h_match  && (anchor_c <= COL_ANCHOR_MAX);
        v_hit   = v_match  && (anchor_r <= ROW_ANCHOR_MAX);
        dp_hit  = dp_match && (anchor_r <= ROW_ANCHOR_MAX) && (anchor_c <= COL_ANCHOR_MAX);
        dm_hit  = dm_match && (anchor_r <= ROW_ANCHOR_MAX) && (anchor_c >= 4'd3);
        any_hit = h_hit || v_hit || dp_hit || dm_hit;
        // Every matching window starts at the anchor, so all players agree.
        if (h_hit)       hit_player = h_player;
        else if (v_hit)  hit_player = v_player;
        else if (dp_hit) hit_player = dp_player;
        else if (dm_hit) hit_player = dm_player;
        else             hit_player = EMPTY;
    end

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            idx     <= '0;
            pending <= 1'b0;
            shadow  <= '0;
            win     <= 1'b0;
            winner  <= EMPTY;
            draw    <= 1'b0;
        end else begin
            // Requests arriving mid-scan collapse into one rescan.
            if (scan_req && state != S_IDLE && state != S_DONE)
                pending <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (scan_req && !win && !draw)
                        state <= S_WAIT_BLANK;
                end

                S_WAIT_BLANK: begin
                    if (vblank_ok) begin
                        idx   <= '0;
                        state <= S_COPY;
                    end
                end

                // ---- copy stage: one board cell per cycle into the shadow ----
                S_COPY: begin
                    shadow[{idx, 1'b0} +: 2] <= board_data;
                    idx <= idx + 6'd1;
                    if (idx == 6'd63)
                        state <= S_CHECK;
                end

                // ---- check stage: one anchor per cycle, first hit wins ----
                S_CHECK: begin
                    if (any_hit) begin
                        win    <= 1'b1;
                        winner <= hit_player;
                        idx    <= '0;
                        state  <= S_DONE;
                    end else if (idx == 6'd63) begin
                        draw  <= board_full(shadow);
                        idx   <= '0;
                        state <= S_DONE;
                    end else begin
                        idx <= idx + 6'd1;
                    end
                end

                // A request landing on the DONE cycle still counts as pending.
                S_DONE: begin
                    pending <= 1'b0;
                    if ((pending || scan_req) && !win && !draw)
                        state <= S_WAIT_BLANK;
                    else
                        state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_scan_controller.sv
// Self-checking bench for board_scan_controller.
// A behavioural board array answers the muxed read port combinationally.
module tb_board_scan_controller;

    logic       clk_25MHz;
    logic       rst_n;
    logic       scan_req;
    logic [9:0] v_count;
    logic [2:0] vga_row_read;
    logic [2:0] vga_col_read;
    logic [1:0] board_data;
    logic [2:0] board_row_read;
    logic [2:0] board_col_read;
    logic [1:0] vga_data;
    logic       scan_busy;
    logic       scan_done;
    logic       win;
    logic [1:0] winner;
    logic       draw;

    logic [1:0] board [64];

    int n_checks = 0;
    int n_fail   = 0;

    board_scan_controller #(.V_ACTIVE(480), .V_TOTAL(525)) dut (
        .clk_25MHz      (clk_25MHz),
        .rst_n          (rst_n),
        .scan_req       (scan_req),
        .v_count        (v_count),
        .vga_row_read   (vga_row_read),
        .vga_col_read   (vga_col_read),
        .board_data     (board_data),
        .board_row_read (board_row_read),
        .board_col_read (board_col_read),
        .vga_data       (vga_data),
        .scan_busy      (scan_busy),
        .scan_done      (scan_done),
        .win            (win),
        .winner         (winner),
        .draw           (draw)
    );

    assign board_data = board[{board_row_read, board_col_read}];

    initial clk_25MHz = 1'b0;
    always #20 clk_25MHz = ~clk_25MHz;

    typedef struct {
        int         pat;
        logic       exp_win;
        logic [1:0] exp_winner;
        logic       exp_draw;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25MHz);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        scan_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic pulse_req();
        scan_req = 1'b1;
        tick();
        scan_req = 1'b0;
    endtask

    task automatic setc(input int r, input int c, input logic [1:0] v);
        board[r*8 + c] = v;
    endtask

    // Alternating column-pair pattern: no run of four in any direction.
    task automatic fill_alternating();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                setc(r, c, ((((c >> 1) + r) & 1) != 0) ? 2'b10 : 2'b01);
    endtask

    task automatic load_pattern(input int pat);
        for (int i = 0; i < 64; i++) board[i] = 2'b00;
        case (pat)
            0:  for (int c = 2; c <= 5; c++) setc(0, c, 2'b01);
            1:  for (int r = 0; r <= 3; r++) setc(r, 7, 2'b10);
            2:  begin setc(0,6,2'b10); setc(1,5,2'b10); setc(2,4,2'b10); setc(3,3,2'b10); end
            3:  begin setc(0,5,2'b01); setc(0,6,2'b01); setc(0,7,2'b01); setc(1,0,2'b01); end
            4:  fill_alternating();
            5:  begin setc(2,1,2'b01); setc(3,2,2'b01); setc(4,3,2'b01); setc(5,4,2'b01); end
            6:  for (int c = 4; c <= 7; c++) setc(7, c, 2'b10);
            7:  for (int r = 4; r <= 7; r++) setc(r, 0, 2'b01);
            8:  ;
            9:  begin
                    for (int c = 0; c <= 3; c++) setc(0, c, 2'b10);
                    for (int c = 0; c <= 3; c++) setc(5, c, 2'b01);
                end
            10: begin fill_alternating(); setc(7, 7, 2'b00); end
            11: begin setc(0,2,2'b01); setc(1,1,2'b01); setc(2,0,2'b01); setc(3,7,2'b01); end
            12: begin setc(0,5,2'b10); setc(1,6,2'b10); setc(2,7,2'b10); setc(3,0,2'b10); end
            default: ;
        endcase
    endtask

    // Copy is recognised by the board address leaving the renderer address.
    task automatic wait_copy(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (board_row_read != vga_row_read || board_col_read != vga_col_read) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_until_done(input int budget, output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            cycles++;
            if (scan_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        int cycles;
        int extra_done;
        bit addr_bad;

        vecs[0]  = '{0,  1'b1, 2'b01, 1'b0};
        vecs[1]  = '{1,  1'b1, 2'b10, 1'b0};
        vecs[2]  = '{2,  1'b1, 2'b10, 1'b0};
        vecs[3]  = '{3,  1'b0, 2'b00, 1'b0};
        vecs[4]  = '{4,  1'b0, 2'b00, 1'b1};
        vecs[5]  = '{5,  1'b1, 2'b01, 1'b0};
        vecs[6]  = '{6,  1'b1, 2'b10, 1'b0};
        vecs[7]  = '{7,  1'b1, 2'b01, 1'b0};
        vecs[8]  = '{8,  1'b0, 2'b00, 1'b0};
        vecs[9]  = '{9,  1'b1, 2'b10, 1'b0};
        vecs[10] = '{10, 1'b0, 2'b00, 1'b0};
        vecs[11] = '{11, 1'b0, 2'b00, 1'b0};
        vecs[12] = '{12, 1'b0, 2'b00, 1'b0};

        rst_n        = 1'b0;
        scan_req     = 1'b0;
        v_count      = 10'd0;
        vga_row_read = 3'd7;
        vga_col_read = 3'd7;
        load_pattern(0);
        board[63] = 2'b10;
        do_reset();

        // Reset state and renderer pass-through
        chk("rst_busy",   {31'b0, scan_busy}, 0);
        chk("rst_done",   {31'b0, scan_done}, 0);
        chk("rst_win",    {31'b0, win}, 0);
        chk("rst_winner", {30'b0, winner}, 0);
        chk("rst_draw",   {31'b0, draw}, 0);
        chk("rst_addr",   {26'b0, board_row_read, board_col_read}, {26'b0, 6'd63});
        chk("rst_vdata",  {30'b0, vga_data}, 32'd2);

        // Test 1: request outside blanking waits for line 480
        v_count = 10'd100;
        pulse_req();
        for (int i = 0; i < 5; i++) tick();
        chk("t1_busy_wait", {31'b0, scan_busy}, 1);
        chk("t1_addr_wait", {26'b0, board_row_read, board_col_read}, {26'b0, 6'd63});
        v_count = 10'd480;
        wait_copy(4, ok);
        chk("t1_copy_start", {31'b0, ok}, 1);
        addr_bad = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if ({board_row_read, board_col_read} != 6'(k)) addr_bad = 1'b1;
        end
        chk("t1_copy_addr", {31'b0, addr_bad}, 0);
        run_until_done(200, cycles, ok);
        cycles += 10;
        chk("t1_done_seen", {31'b0, ok}, 1);
        chk("t1_latency_max", {31'b0, (cycles <= 130)}, 1);
        chk("t1_latency_min", {31'b0, (cycles >= 65)}, 1);
        chk("t1_win", {31'b0, win}, 1);
        chk("t1_winner", {30'b0, winner}, 32'd1);
        tick();
        chk("t1_done_width", {31'b0, scan_done}, 0);

        // Table-driven patterns at line 480
        foreach (vecs[i]) begin
            do_reset();
            load_pattern(vecs[i].pat);
            v_count = 10'd480;
            pulse_req();
            run_until_done(300, cycles, ok);
            chk($sformatf("v%0d_done_seen", i), {31'b0, ok}, 1);
            chk($sformatf("v%0d_win", i),    {31'b0, win},    {31'b0, vecs[i].exp_win});
            chk($sformatf("v%0d_winner", i), {30'b0, winner}, {30'b0, vecs[i].exp_winner});
            chk($sformatf("v%0d_draw", i),   {31'b0, draw},   {31'b0, vecs[i].exp_draw});
            tick();
            chk($sformatf("v%0d_done_width", i), {31'b0, scan_done}, 0);
            chk($sformatf("v%0d_idle", i), {31'b0, scan_busy}, 0);
            // Sticky result: a further request is ignored after win/draw
            pulse_req();
            chk($sformatf("v%0d_sticky", i), {31'b0, scan_busy},
                {31'b0, ~(vecs[i].exp_win | vecs[i].exp_draw)});
        end

        // Test 5: two requests during CHECK -> exactly one rescan at next blanking
        do_reset();
        load_pattern(3);
        v_count = 10'd480;
        pulse_req();
        wait_copy(4, ok);
        chk("t5_copy_start", {31'b0, ok}, 1);
        for (int i = 0; i < 64; i++) tick();
        v_count = 10'd100;
        pulse_req();
        tick();
        pulse_req();
        run_until_done(100, cycles, ok);
        chk("t5_first_done", {31'b0, ok}, 1);
        tick();
        chk("t5_rescan_busy", {31'b0, scan_busy}, 1);
        addr_bad = 1'b0;
        extra_done = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (board_row_read != vga_row_read || board_col_read != vga_col_read) addr_bad = 1'b1;
            if (scan_done) extra_done++;
        end
        chk("t5_waits_blank", {31'b0, addr_bad}, 0);
        v_count = 10'd480;
        run_until_done(200, cycles, ok);
        chk("t5_second_done", {31'b0, ok}, 1);
        for (int i = 0; i < 200; i++) begin
            tick();
            if (scan_done) extra_done++;
        end
        chk("t5_no_third_done", extra_done, 0);
        chk("t5_idle_after", {31'b0, scan_busy}, 0);

        // Request on the last line waits for the next frame; line 523 is allowed
        do_reset();
        load_pattern(8);
        v_count = 10'd524;
        pulse_req();
        addr_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (board_row_read != vga_row_read || board_col_read != vga_col_read) addr_bad = 1'b1;
        end
        v_count = 10'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (board_row_read != vga_row_read || board_col_read != vga_col_read) addr_bad = 1'b1;
        end
        chk("t5_line524_hold", {31'b0, addr_bad}, 0);
        chk("t5_line524_busy", {31'b0, scan_busy}, 1);
        v_count = 10'd480;
        wait_copy(4, ok);
        chk("t5_next_frame_copy", {31'b0, ok}, 1);

        do_reset();
        v_count = 10'd523;
        pulse_req();
        wait_copy(4, ok);
        chk("t5_line523_copy", {31'b0, ok}, 1);

        // Test 6: reset in the middle of COPY
        do_reset();
        load_pattern(0);
        board[5*8 + 3] = 2'b10;
        vga_row_read = 3'd5;
        vga_col_read = 3'd3;
        v_count = 10'd480;
        pulse_req();
        wait_copy(4, ok);
        chk("t6_copy_start", {31'b0, ok}, 1);
        for (int i = 0; i < 30; i++) tick();
        chk("t6_addr_idx30", {26'b0, board_row_read, board_col_read}, 32'd30);
        rst_n = 1'b0;
        tick();
        chk("t6_busy",   {31'b0, scan_busy}, 0);
        chk("t6_done",   {31'b0, scan_done}, 0);
        chk("t6_win",    {31'b0, win}, 0);
        chk("t6_winner", {30'b0, winner}, 0);
        chk("t6_draw",   {31'b0, draw}, 0);
        chk("t6_addr",   {26'b0, board_row_read, board_col_read}, {26'b0, 3'd5, 3'd3});
        chk("t6_vdata",  {30'b0, vga_data}, 32'd2);
        rst_n = 1'b1;
        tick();
        chk("t6_stays_idle", {31'b0, scan_busy}, 0);
        pulse_req();
        run_until_done(300, cycles, ok);
        chk("t6_rescan_done", {31'b0, ok}, 1);
        chk("t6_rescan_win", {31'b0, win}, 1);
        chk("t6_rescan_winner", {30'b0, winner}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
